fwd_hazard_unit: RTL and testbench



---
 rtl/rv32i_types.sv | 17 +
 rtl/fwd_hazard_unit_if.sv | 59 +++++
 rtl/fwd_match.sv | 30 +++
 rtl/fwd_hazard_unit.sv | 152 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register index, forwarding entry, select encoding.
package rv32i_types;

  // Architectural register index, used for every 5-bit register field.
  typedef logic [4:0] rv32i_reg;

  // One tracked in-flight producer in the stages after EX.
  typedef struct packed {
    logic     valid;
    rv32i_reg rd;
    logic     is_load;
  } fwd_entry_t;

  // Select value meaning "take the operand from the register file".
  localparam int FWD_SEL_REGFILE = 0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// EX-side interface of the forwarding/hazard unit.
// Optional statistics ports exist only when FWD_HAZARD_STATS_EN is defined.
//
// Flow control: this block has no valid/ready pair. ex_valid qualifies the
// EX-stage fields. advance is the pipeline's own move signal; a cycle moves
// an instruction out of EX only when advance=1 and stall=0. stall is purely
// combinational and does not look at advance.
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
);
  import rv32i_types::*;

  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                     advance;
  logic                     flush;
  logic                     ex_valid;
  logic [NUM_SRC*5-1:0]     ex_rs;
  rv32i_reg                 ex_rd;
  logic                     ex_wr;
  logic                     ex_is_load;
  logic                     ex_is_long;
  logic                     long_wb_valid;
  rv32i_reg                 long_wb_rd;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]              stat_stall_cycles;
  logic [31:0]              stat_fwd_count;
`endif

`ifdef FWD_HAZARD_STATS_EN
  modport master (
    output advance, flush, ex_valid, ex_rs, ex_rd, ex_wr, ex_is_load,
           ex_is_long, long_wb_valid, long_wb_rd,
    input  fwd_sel, stall, stat_stall_cycles, stat_fwd_count
  );

  modport slave (
    input  advance, flush, ex_valid, ex_rs, ex_rd, ex_wr, ex_is_load,
           ex_is_long, long_wb_valid, long_wb_rd,
    output fwd_sel, stall, stat_stall_cycles, stat_fwd_count
  );
`else
  modport master (
    output advance, flush, ex_valid, ex_rs, ex_rd, ex_wr, ex_is_load,
           ex_is_long, long_wb_valid, long_wb_rd,
    input  fwd_sel, stall
  );

  modport slave (
    input  advance, flush, ex_valid, ex_rs, ex_rd, ex_wr, ex_is_load,
           ex_is_long, long_wb_valid, long_wb_rd,
    output fwd_sel, stall
  );
`endif

endinterface

// File: rtl/fwd_match.sv
// Youngest-producer priority encoder for one source operand over the
// tracked stages. Stage 1 is the youngest, so the lowest matching index wins.
module fwd_match
  import rv32i_types::*;
#(
  parameter int DEPTH = 2
) (
  input  rv32i_reg                         rs,
  input  fwd_entry_t [DEPTH:1]             entries,
  output logic [$clog2(DEPTH+1)-1:0]       sel,
  output logic                             near_load
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  // Scan oldest to youngest so the youngest match overwrites; x0 never matches.
  always_comb begin
    sel       = SEL_W'(FWD_SEL_REGFILE);
    near_load = 1'b0;
    if (rs != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (entries[k].valid && (entries[k].rd == rs)) begin
          sel = SEL_W'(k);
        end
      end
    end
    near_load = (sel == SEL_W'(1)) && entries[1].is_load;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and hazard stall generation for the EX stage.
// Tracks DEPTH stages of in-flight destinations plus a pending scoreboard for
// long-latency (mul/div) results. Optional counters: FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
  import rv32i_types::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int NREGS   = 32
) (
  input logic               clk,
  input logic               rst,
  fwd_hazard_unit_if.slave  bus
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  fwd_entry_t [DEPTH:1]     ent;
  fwd_entry_t               ent_in;
  logic [NREGS-1:0]         pending;
  logic [NREGS-1:0]         pending_nxt;
  logic [SEL_W-1:0]         sel_raw [NUM_SRC];
  logic [NUM_SRC-1:0]       near_load;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_w;
  logic                     load_use;
  logic                     long_raw;
  logic                     long_waw;
  logic                     stall_w;
  logic                     long_set;
  logic                     long_clr;
  rv32i_reg                 rs_cur;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_match #(.DEPTH(DEPTH)) u_match (
      .rs        (bus.ex_rs[5*gi +: 5]),
      .entries   (ent),
      .sel       (sel_raw[gi]),
      .near_load (near_load[gi])
    );
  end

  // Forward selects are only meaningful for a real EX instruction.
  always_comb begin
    fwd_sel_w = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel_w[i*SEL_W +: SEL_W] = bus.ex_valid ? sel_raw[i] : '0;
    end
  end

  // Load-use, long-op RAW and long-op WAW hazards combine into one stall.
  always_comb begin
    rs_cur   = '0;
    long_raw = 1'b0;
    load_use = |near_load;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_cur = bus.ex_rs[5*i +: 5];
      if ((rs_cur != '0) && pending[rs_cur]) begin
        long_raw = 1'b1;
      end
    end
    long_raw = long_raw && bus.ex_valid;
    long_waw = bus.ex_valid && (bus.ex_wr || bus.ex_is_long) &&
               (bus.ex_rd != '0) && pending[bus.ex_rd];
    stall_w  = load_use || long_raw || long_waw;
  end

  assign bus.fwd_sel = fwd_sel_w;
  assign bus.stall   = stall_w;

  // New stage-1 entry; a stalled, long or non-writing EX becomes a bubble.
  always_comb begin
    ent_in         = '0;
    ent_in.valid   = bus.ex_valid && bus.ex_wr && !bus.ex_is_long &&
                     !stall_w && (bus.ex_rd != '0);
    ent_in.rd      = bus.ex_rd;
    ent_in.is_load = bus.ex_is_load;
  end

  // Shadow pipeline: flush clears, advance shifts, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
    end else if (bus.flush) begin
      ent <= '0;
    end else if (bus.advance) begin
      ent[1] <= ent_in;
      for (int k = 2; k <= DEPTH; k++) begin
        ent[k] <= ent[k-1];
      end
    end
  end

  // Scoreboard next state: writeback clear first, then issue set wins.
  always_comb begin
    long_clr    = bus.long_wb_valid && (bus.long_wb_rd != '0);
    long_set    = bus.ex_valid && bus.ex_is_long && !stall_w && bus.advance &&
                  !bus.flush && (bus.ex_rd != '0);
    pending_nxt = pending;
    if (long_clr) begin
      pending_nxt[bus.long_wb_rd] = 1'b0;
    end
    if (long_set) begin
      pending_nxt[bus.ex_rd] = 1'b1;
    end
  end

  // Scoreboard register; updates every cycle and is untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
  logic [31:0] fwd_inc;
  logic [32:0] fwd_sum;

  // Number of sources forwarded this cycle and the widened running sum.
  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_sel_w[i*SEL_W +: SEL_W] != '0) begin
        fwd_inc = fwd_inc + 32'd1;
      end
    end
    fwd_sum = {1'b0, fwd_cnt} + {1'b0, fwd_inc};
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall_w && bus.advance && bus.ex_valid && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bus.advance && !stall_w && bus.ex_valid) begin
        fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
    end
  end

  assign bus.stat_stall_cycles = stall_cnt;
  assign bus.stat_fwd_count    = fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding, load-use, long-op
// scoreboard, hold/flush and reset, with hand-computed expectations.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fwd_hazard_unit_if #(.NUM_SRC(2), .DEPTH(2)) bus ();

  fwd_hazard_unit #(.NUM_SRC(2), .DEPTH(2), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one EX instruction (rs2/rs1 packed as {rs2, rs1})
  task automatic ex(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic wr, input logic ld,
                    input logic lng);
    bus.ex_valid   = v;
    bus.ex_rs      = {rs2, rs1};
    bus.ex_rd      = rd;
    bus.ex_wr      = wr;
    bus.ex_is_load = ld;
    bus.ex_is_long = lng;
  endtask

  // Checker: compares observed against expected, counts and reports
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.advance       = 1'b1;
    bus.flush         = 1'b0;
    bus.long_wb_valid = 1'b0;
    bus.long_wb_rd    = '0;
    ex(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    ex(1, 1, 2, 5, 1, 0, 0);
    #1;
    check("reset_sel", 32'(bus.fwd_sel), 32'd0);
    check("reset_stall", 32'(bus.stall), 32'd0);
    tick();

    // Back-to-back ALU forwarding, then stage 2, then aged out
    ex(1, 5, 0, 6, 1, 0, 0);
    #1;
    check("alu_s1_sel", 32'(bus.fwd_sel), 32'd1);
    check("alu_s1_stall", 32'(bus.stall), 32'd0);
    tick();
    ex(1, 5, 6, 0, 0, 0, 0);
    #1;
    check("alu_s2_and_s1", 32'(bus.fwd_sel), 32'h6);
    tick();
    #1;
    check("alu_aged_out", 32'(bus.fwd_sel), 32'h8);
    tick();

    // Youngest wins; x0 never forwards
    ex(1, 1, 1, 7, 1, 0, 0);
    tick();
    ex(1, 0, 0, 7, 1, 0, 0);
    tick();
    ex(1, 0, 7, 0, 1, 0, 0);
    #1;
    check("youngest_wins", 32'(bus.fwd_sel), 32'h4);
    tick();
    ex(1, 0, 7, 0, 0, 0, 0);
    #1;
    check("x0_no_fwd", 32'(bus.fwd_sel), 32'h8);
    tick();

    // Load-use stall, then forward from stage 2
    ex(1, 1, 2, 3, 1, 1, 0);
    tick();
    ex(1, 3, 0, 8, 1, 0, 0);
    #1;
    check("ld_use_stall", 32'(bus.stall), 32'd1);
    check("ld_use_sel", 32'(bus.fwd_sel), 32'd1);
    tick();
    #1;
    check("ld_after_stall", 32'(bus.stall), 32'd0);
    check("ld_after_sel", 32'(bus.fwd_sel), 32'd2);
    tick();
    ex(0, 8, 0, 0, 0, 0, 0);
    #1;
    check("invalid_ex_sel", 32'(bus.fwd_sel), 32'd0);
    check("invalid_ex_stall", 32'(bus.stall), 32'd0);
    tick();

    // Long op: RAW and WAW stalls until one cycle after writeback
    ex(1, 1, 2, 9, 0, 0, 1);
    #1;
    check("long_issue_stall", 32'(bus.stall), 32'd0);
    tick();
    ex(1, 9, 0, 10, 1, 0, 0);
    #1;
    check("long_raw_stall", 32'(bus.stall), 32'd1);
    check("long_raw_sel", 32'(bus.fwd_sel), 32'd0);
    tick();
    #1;
    check("long_raw_stall2", 32'(bus.stall), 32'd1);
    ex(1, 0, 0, 9, 1, 0, 0);
    #1;
    check("long_waw_alu", 32'(bus.stall), 32'd1);
    ex(1, 1, 0, 9, 0, 0, 0);
    #1;
    check("long_nowrite_ok", 32'(bus.stall), 32'd0);
    ex(1, 0, 0, 9, 0, 0, 1);
    #1;
    check("long_waw_long", 32'(bus.stall), 32'd1);
    ex(1, 9, 0, 10, 1, 0, 0);
    bus.long_wb_valid = 1'b1;
    bus.long_wb_rd    = 5'd9;
    #1;
    check("long_wb_same_cyc", 32'(bus.stall), 32'd1);
    tick();
    bus.long_wb_valid = 1'b0;
    bus.long_wb_rd    = '0;
    #1;
    check("long_cleared_stall", 32'(bus.stall), 32'd0);
    check("long_cleared_sel", 32'(bus.fwd_sel), 32'd0);
    tick();

    // Hold and flush; pending survives flush
    ex(1, 1, 2, 4, 0, 0, 1);
    tick();
    ex(1, 1, 2, 11, 1, 0, 0);
    tick();
    bus.advance = 1'b0;
    ex(1, 11, 0, 0, 0, 0, 0);
    #1;
    check("hold_sel", 32'(bus.fwd_sel), 32'd1);
    tick();
    #1;
    check("hold_sel_after", 32'(bus.fwd_sel), 32'd1);
    bus.flush   = 1'b1;
    bus.advance = 1'b1;
    tick();
    bus.flush = 1'b0;
    ex(1, 11, 4, 0, 0, 0, 0);
    #1;
    check("flush_sel", 32'(bus.fwd_sel), 32'd0);
    check("flush_pending_kept", 32'(bus.stall), 32'd1);

    // Reset mid-stall
    ex(1, 1, 2, 3, 1, 1, 0);
    #1;
    check("pre_rst_no_stall", 32'(bus.stall), 32'd0);
    tick();
    ex(1, 3, 4, 0, 0, 0, 0);
    #1;
    check("pre_rst_stall", 32'(bus.stall), 32'd1);
    check("pre_rst_sel", 32'(bus.fwd_sel), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_sel", 32'(bus.fwd_sel), 32'd0);
`ifdef FWD_HAZARD_STATS_EN
    check("rst_stat_stall", bus.stat_stall_cycles, 32'd0);
    check("rst_stat_fwd", bus.stat_fwd_count, 32'd0);
`endif

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
